// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS constants and helpers
package tmds_pkg;

    localparam int CNT_W = 6;

    localparam logic [9:0] TOKEN_00  = 10'b1101010100;
    localparam logic [9:0] TOKEN_01  = 10'b0010101011;
    localparam logic [9:0] TOKEN_10  = 10'b0101010100;
    localparam logic [9:0] TOKEN_11  = 10'b1010101011;
    localparam logic [9:0] TOKEN_RST = TOKEN_00;

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = TOKEN_00;
            2'b01:   tok = TOKEN_01;
            2'b10:   tok = TOKEN_10;
            default: tok = TOKEN_11;
        endcase
        return tok;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_tmds_channel.sv
// rtl/tx_tmds_channel.sv - one TMDS 8b/10b channel: transition minimisation, DC balance, control tokens
module tx_tmds_channel
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       vde_i,
    input  logic       c1_i,
    input  logic       c0_i,
    output logic [9:0] sym_o
);

    logic [7:0] din;
    logic [3:0] n1_in;
    logic       use_xnor;
    logic       acc;
    logic [8:0] qm_d;
    logic [8:0] qm_q;
    logic       vde_q;
    logic       c1_q;
    logic       c0_q;

    // Blanking data is forced to zero so undefined pixels never reach q_m.
    always_comb begin
        din      = vde_i ? data_i : 8'h00;
        n1_in    = ones8(din);
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !din[0]);
        acc      = din[0];
        qm_d     = '0;
        qm_d[0]  = acc;
        for (int i = 1; i < 8; i++) begin
            acc     = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
            qm_d[i] = acc;
        end
        qm_d[8] = ~use_xnor;
    end

    logic signed [CNT_W-1:0] cnt_q;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] n1_qm;
    logic signed [CNT_W-1:0] n0_qm;
    logic signed [CNT_W-1:0] diff;
    logic [9:0]              sym_q;
    logic [9:0]              sym_d;

    always_comb begin
        n1_qm = $signed({2'b00, ones8(qm_q[7:0])});
        n0_qm = 6'sd8 - n1_qm;
        diff  = n1_qm - n0_qm;
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!vde_q) begin
            sym_d = ctrl_token(c1_q, c0_q);
            cnt_d = '0;
        end else if ((cnt_q == '0) || (n1_qm == n0_qm)) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((!cnt_q[CNT_W-1] && (n1_qm > n0_qm)) ||
                     ( cnt_q[CNT_W-1] && (n0_qm > n1_qm))) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + diff - (qm_q[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qm_q  <= '0;
            vde_q <= 1'b0;
            c1_q  <= 1'b0;
            c0_q  <= 1'b0;
            sym_q <= TOKEN_RST;
            cnt_q <= '0;
        end else begin
            qm_q  <= qm_d;
            vde_q <= vde_i;
            c1_q  <= c1_i;
            c0_q  <= c0_i;
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/tx_tmds_encoder.sv
// rtl/tx_tmds_encoder.sv - three-channel TMDS encoder: byte mapping and control routing
module tx_tmds_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned PIX_ORDER = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] In_pData,
    input  logic        In_pVSync,
    input  logic        In_pHSync,
    input  logic        In_pVDE,
    output logic [9:0]  Tmds_Ch0,
    output logic [9:0]  Tmds_Ch1,
    output logic [9:0]  Tmds_Ch2
);

    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;

    assign red = In_pData[23:16];
    assign grn = (PIX_ORDER == 0) ? In_pData[7:0]  : In_pData[15:8];
    assign blu = (PIX_ORDER == 0) ? In_pData[15:8] : In_pData[7:0];

    // Only the blue channel carries sync; the others always send the 00 token.
    tx_tmds_channel u_ch0 (
        .clk    (clk),
        .rst    (rst),
        .data_i (blu),
        .vde_i  (In_pVDE),
        .c1_i   (In_pVSync),
        .c0_i   (In_pHSync),
        .sym_o  (Tmds_Ch0)
    );

    tx_tmds_channel u_ch1 (
        .clk    (clk),
        .rst    (rst),
        .data_i (grn),
        .vde_i  (In_pVDE),
        .c1_i   (1'b0),
        .c0_i   (1'b0),
        .sym_o  (Tmds_Ch1)
    );

    tx_tmds_channel u_ch2 (
        .clk    (clk),
        .rst    (rst),
        .data_i (red),
        .vde_i  (In_pVDE),
        .c1_i   (1'b0),
        .c0_i   (1'b0),
        .sym_o  (Tmds_Ch2)
    );

endmodule

// File: tb/tb_tx_tmds_encoder.sv
// tb/tb_tx_tmds_encoder.sv - self-checking bench for tx_tmds_encoder with a reference model
module tb_tx_tmds_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data = '0;
    logic        vs = 1'b0;
    logic        hs = 1'b0;
    logic        vde = 1'b0;
    logic [9:0]  a0, a1, a2, b0, b1, b2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tx_tmds_encoder #(.PIX_ORDER(0)) dut_a (
        .clk(clk), .rst(rst), .In_pData(data), .In_pVSync(vs), .In_pHSync(hs),
        .In_pVDE(vde), .Tmds_Ch0(a0), .Tmds_Ch1(a1), .Tmds_Ch2(a2)
    );

    tx_tmds_encoder #(.PIX_ORDER(1)) dut_b (
        .clk(clk), .rst(rst), .In_pData(data), .In_pVSync(vs), .In_pHSync(hs),
        .In_pVDE(vde), .Tmds_Ch0(b0), .Tmds_Ch1(b1), .Tmds_Ch2(b2)
    );

    // Reference model state: one stage of pending input, expected outputs, running disparity
    logic [23:0] s1_data;
    logic        s1_vde, s1_vs, s1_hs;
    logic [9:0]  exp_s[2][3];
    int          mcnt[2][3];

    function automatic logic [9:0] dut_sym(input int k, input int c);
        if (k == 0) return (c == 0) ? a0 : (c == 1) ? a1 : a2;
        return (c == 0) ? b0 : (c == 1) ? b1 : b2;
    endfunction

    function automatic logic [9:0] model_sym(input int k, input int c, input logic [7:0] d,
                                             input logic v, input logic c1, input logic c0);
        int n1, n1q, n0q, cnt;
        logic xn, q8;
        logic [7:0] q;
        logic [9:0] s;
        if (!v) begin
            mcnt[k][c] = 0;
            case ({c1, c0})
                2'b00:   s = 10'h354;
                2'b01:   s = 10'h0AB;
                2'b10:   s = 10'h154;
                default: s = 10'h2AB;
            endcase
        end else begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            // chain bit i = parity of d[i:0], inverted once per XNOR step
            for (int i = 0; i < 8; i++) begin
                q[i] = 1'(($countones(d & 8'((1 << (i + 1)) - 1)) + (xn ? i : 0)) % 2);
            end
            q8  = !xn;
            n1q = $countones(q);
            n0q = 8 - n1q;
            cnt = mcnt[k][c];
            if (cnt == 0 || n1q == n0q) begin
                s = {~q8, q8, q8 ? q : ~q};
                cnt = cnt + (q8 ? (n1q - n0q) : (n0q - n1q));
            end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
                s = {1'b1, q8, ~q};
                cnt = cnt + (q8 ? 2 : 0) + n0q - n1q;
            end else begin
                s = {1'b0, q8, q};
                cnt = cnt + (n1q - n0q) - (q8 ? 0 : 2);
            end
            mcnt[k][c] = cnt;
        end
        return s;
    endfunction

    task automatic cycle();
        logic [7:0] r, g, b;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 3; c++) begin
                    exp_s[k][c] = 10'h354;
                    mcnt[k][c]  = 0;
                end
            end
            s1_data = '0; s1_vde = 1'b0; s1_vs = 1'b0; s1_hs = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = s1_data[23:16];
                g = (k == 0) ? s1_data[7:0]  : s1_data[15:8];
                b = (k == 0) ? s1_data[15:8] : s1_data[7:0];
                exp_s[k][0] = model_sym(k, 0, b, s1_vde, s1_vs, s1_hs);
                exp_s[k][1] = model_sym(k, 1, g, s1_vde, 1'b0, 1'b0);
                exp_s[k][2] = model_sym(k, 2, r, s1_vde, 1'b0, 1'b0);
            end
            s1_data = data; s1_vde = vde; s1_vs = vs; s1_hs = hs;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            data = 24'($urandom); vde = 1'($urandom); vs = 1'($urandom); hs = 1'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 3; c++) begin
                    n_total++;
                    if (dut_sym(k, c) !== 10'h354)
                        $display("FAIL reset inst%0d ch%0d: got %h expected 354", k, c, dut_sym(k, c));
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [9:0] tk[4];
        tk[0] = 10'h354; tk[1] = 10'h0AB; tk[2] = 10'h154; tk[3] = 10'h2AB;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            vde = 1'b0;
            data = 24'($urandom);
            {vs, hs} = (j < 4) ? 2'(j) : 2'b00;
            cycle();
            if (j >= 1 && j <= 4) begin
                for (int k = 0; k < 2; k++) begin
                    n_total++;
                    if (dut_sym(k, 0) !== tk[j-1])
                        $display("FAIL blank_ch0 inst%0d step%0d: got %h expected %h", k, j, dut_sym(k, 0), tk[j-1]);
                    else n_pass++;
                    for (int c = 1; c < 3; c++) begin
                        n_total++;
                        if (dut_sym(k, c) !== 10'h354)
                            $display("FAIL blank_ch%0d inst%0d: got %h expected 354", c, k, dut_sym(k, c));
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_dc_balance();
        logic [9:0] ex[3];
        ex[0] = 10'h100; ex[1] = 10'h3FF; ex[2] = 10'h100;
        for (int j = 0; j < 5; j++) begin
            vs = 1'b0; hs = 1'b0;
            vde = (j < 3);
            data = 24'h000000;
            cycle();
            if (j >= 1 && j <= 3) begin
                for (int k = 0; k < 2; k++) begin
                    for (int c = 0; c < 3; c++) begin
                        n_total++;
                        if (dut_sym(k, c) !== ex[j-1])
                            $display("FAIL dc_balance inst%0d ch%0d px%0d: got %h expected %h", k, c, j-1, dut_sym(k, c), ex[j-1]);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_all_ones();
        for (int j = 0; j < 4; j++) begin
            vde  = (j < 2);
            data = (j == 0) ? 24'hFFFFFF : 24'h000000;
            cycle();
            if (j == 1 || j == 2) begin
                for (int k = 0; k < 2; k++) begin
                    for (int c = 0; c < 3; c++) begin
                        n_total++;
                        if (dut_sym(k, c) !== ((j == 1) ? 10'h200 : 10'h3FF))
                            $display("FAIL all_ones inst%0d ch%0d step%0d: got %h expected %h", k, c, j, dut_sym(k, c),
                                     (j == 1) ? 10'h200 : 10'h3FF);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_vde_fall();
        for (int j = 0; j < 7; j++) begin
            vs = 1'b0;
            hs = (j == 4);
            vde = (j < 4) || (j == 5);
            data = (j < 4) ? 24'($urandom) : 24'h000000;
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (j >= 1 && j <= 4) begin
                    for (int c = 0; c < 3; c++) begin
                        n_total++;
                        if (dut_sym(k, c) !== exp_s[k][c])
                            $display("FAIL vde_fall_px inst%0d ch%0d: got %h expected %h", k, c, dut_sym(k, c), exp_s[k][c]);
                        else n_pass++;
                    end
                end
                if (j == 5) begin
                    n_total++;
                    if (dut_sym(k, 0) !== 10'h0AB || dut_sym(k, 1) !== 10'h354)
                        $display("FAIL vde_fall_token inst%0d: got %h/%h expected 0ab/354", k, dut_sym(k, 0), dut_sym(k, 1));
                    else n_pass++;
                end
                if (j == 6) begin
                    for (int c = 0; c < 3; c++) begin
                        n_total++;
                        if (dut_sym(k, c) !== 10'h100)
                            $display("FAIL vde_fall_restart inst%0d ch%0d: got %h expected 100", k, c, dut_sym(k, c));
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_frame();
        for (int line = 0; line < 8; line++) begin
            for (int x = 0; x < 800; x++) begin
                vde  = (line < 6) && (x < 640);
                hs   = (x >= 656) && (x < 752);
                vs   = (line == 7);
                data = vde ? 24'($urandom) : 24'bx;
                rst  = (line == 2) && (x == 320);
                cycle();
                for (int k = 0; k < 2; k++) begin
                    for (int c = 0; c < 3; c++) begin
                        n_total++;
                        if (rst) begin
                            if (dut_sym(k, c) !== 10'h354)
                                $display("FAIL midline_rst inst%0d ch%0d: got %h expected 354", k, c, dut_sym(k, c));
                            else n_pass++;
                        end else begin
                            if (dut_sym(k, c) !== exp_s[k][c])
                                $display("FAIL frame inst%0d ch%0d line%0d x%0d: got %h expected %h",
                                         k, c, line, x, dut_sym(k, c), exp_s[k][c]);
                            else n_pass++;
                        end
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_dc_balance();
        test_all_ones();
        test_vde_fall();
        test_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
